// File: rtl/vga_timing_gen.sv
// Raster timing generator for 640x480@60: pixel/line counters plus sync, blanking and tick decodes.
// Optional colour-bar test pattern on rgb_test when VGA_TESTPAT_EN is defined.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int EOF_LINE  = 481
) (
  input  logic       clk25M,
  input  logic       reset,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       vga_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_tick,
  output logic       frame_tick
`ifdef VGA_TESTPAT_EN
  ,
  output logic [2:0] rgb_test
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] EOF_Y    = 10'(EOF_LINE);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_chk
      $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit the 10-bit counters");
    end
  endgenerate

  always_ff @(posedge clk25M) begin
    if (!reset) begin
      x <= '0;
      y <= '0;
    end else if (x == H_LAST) begin
      x <= '0;
      y <= (y == V_LAST) ? '0 : y + 10'd1;
    end else begin
      x <= x + 10'd1;
    end
  end

  // Everything below decodes the registered counters, so it is aligned with x/y.
  assign vga_on     = (x < H_VIS) && (y < V_VIS);
  assign hsync      = !((x >= HS_START) && (x < HS_END));
  assign vsync      = !((y >= VS_START) && (y < VS_END));
  assign line_tick  = (x == H_LAST);
  assign frame_tick = (x == '0) && (y == EOF_Y);

`ifdef VGA_TESTPAT_EN
  logic       first_cyc;
  logic [2:0] bar;

  always_ff @(posedge clk25M) begin
    first_cyc <= !reset;
  end

  // Bar index x/80 by threshold compares; no divider.
  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (x >= 10'(80 * i)) bar = 3'(i);
    end
    rgb_test = (vga_on && !first_cyc) ? bar : 3'b000;
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: vector table, sync/tick periods, mid-frame reset and random resets
// checked against a cycle-count model (vertical timing shortened to keep the run short).
module tb_vga_timing_gen;

  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 8, VF = 2, VS = 2, VB = 3, EOFL = 9;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
`ifdef VGA_TESTPAT_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       on;
    logic       hs;
    logic       vs;
    logic       lt;
    logic       ft;
    logic [2:0] rgb;
  } obs_t;

  typedef struct {
    int         cyc;
    int         ex;
    int         ey;
    logic       on, hs, vs, lt, ft;
    logic [2:0] rgb;
  } vec_t;

  logic       clk25M = 1'b0;
  logic       reset;
  logic [9:0] x, y;
  logic       vga_on, hsync, vsync, line_tick, frame_tick;
  logic [2:0] rgb_obs;

  int checks = 0;
  int failures = 0;

  always #20 clk25M = ~clk25M;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .EOF_LINE(EOFL)
  ) dut (
    .clk25M    (clk25M),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .vga_on    (vga_on),
    .hsync     (hsync),
    .vsync     (vsync),
    .line_tick (line_tick),
    .frame_tick(frame_tick)
`ifdef VGA_TESTPAT_EN
    ,
    .rgb_test  (rgb_obs)
`endif
  );

`ifndef VGA_TESTPAT_EN
  assign rgb_obs = 3'b000;
`endif

  function automatic obs_t cur_obs();
    return '{x: x, y: y, on: vga_on, hs: hsync, vs: vsync, lt: line_tick, ft: frame_tick, rgb: rgb_obs};
  endfunction

  // Reference: position is simply cycles-since-reset folded by line and frame length.
  function automatic obs_t model(int n);
    obs_t o;
    int px, py;
    px = n % HT;
    py = (n / HT) % VT;
    o.x   = 10'(px);
    o.y   = 10'(py);
    o.on  = (px < HV) && (py < VV);
    o.hs  = !(px >= HV + HF && px < HV + HF + HS);
    o.vs  = !(py >= VV + VF && py < VV + VF + VS);
    o.lt  = (px == HT - 1);
    o.ft  = (px == 0) && (py == EOFL);
    o.rgb = (TP && o.on) ? 3'(px / 80) : 3'b000;
    return o;
  endfunction

  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got x=%0d y=%0d on/hs/vs/lt/ft=%b%b%b%b%b rgb=%0d want x=%0d y=%0d on/hs/vs/lt/ft=%b%b%b%b%b rgb=%0d",
               name, act.x, act.y, act.on, act.hs, act.vs, act.lt, act.ft, act.rgb,
               exp.x, exp.y, exp.on, exp.hs, exp.vs, exp.lt, exp.ft, exp.rgb);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  int n_mdl = 0;
  bit mdl_ok = 1'b0;

  always @(posedge clk25M) begin
    if (!reset) begin
      n_mdl  <= 0;
      mdl_ok <= 1'b1;
    end else begin
      n_mdl <= (n_mdl + 1) % FRAME;
    end
  end

  always @(negedge clk25M) begin
    if (mdl_ok) chk("model", cur_obs(), model(n_mdl));
  end

  initial begin
    #8000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    obs_t e;
    int cur, t;

    //          cyc    x    y  on hs vs lt ft rgb
    vecs.push_back('{0,     0,   0, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{80,    80,  0, 1, 1, 1, 0, 0, 1});
    vecs.push_back('{639,   639, 0, 1, 1, 1, 0, 0, 7});
    vecs.push_back('{640,   640, 0, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{655,   655, 0, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{656,   656, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{751,   751, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{752,   752, 0, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{799,   799, 0, 0, 1, 1, 1, 0, 0});
    vecs.push_back('{800,   0,   1, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{4080,  80,  5, 1, 1, 1, 0, 0, 1});
    vecs.push_back('{6239,  639, 7, 1, 1, 1, 0, 0, 7});
    vecs.push_back('{6400,  0,   8, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{7200,  0,   9, 0, 1, 1, 0, 1, 0});
    vecs.push_back('{7201,  1,   9, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{7999,  799, 9, 0, 1, 1, 1, 0, 0});
    vecs.push_back('{8000,  0,  10, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{9500,  700,11, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{9600,  0,  12, 0, 1, 1, 0, 0, 0});
    vecs.push_back('{11999, 799,14, 0, 1, 1, 1, 0, 0});
    vecs.push_back('{12000, 0,   0, 1, 1, 1, 0, 0, 0});

    // Reset held for three edges, released on the first x=0 cycle.
    reset = 1'b0;
    repeat (3) @(negedge clk25M);
    reset = 1'b1;

    cur = 0;
    foreach (vecs[i]) begin
      repeat (vecs[i].cyc - cur) @(negedge clk25M);
      cur = vecs[i].cyc;
      e = '{x: 10'(vecs[i].ex), y: 10'(vecs[i].ey), on: vecs[i].on, hs: vecs[i].hs,
            vs: vecs[i].vs, lt: vecs[i].lt, ft: vecs[i].ft, rgb: TP ? vecs[i].rgb : 3'b000};
      chk($sformatf("vec%0d", i), cur_obs(), e);
    end

    // Tick periods, with bounded waits.
    t = 0;
    while (!frame_tick && t < FRAME + 10) begin @(negedge clk25M); t++; end
    t = 0;
    do begin @(negedge clk25M); t++; end while (!frame_tick && t < FRAME + 10);
    chk_int("frame_period", t, FRAME);

    t = 0;
    while (!line_tick && t < HT + 10) begin @(negedge clk25M); t++; end
    t = 0;
    do begin @(negedge clk25M); t++; end while (!line_tick && t < HT + 10);
    chk_int("line_period", t, HT);

    // Mid-frame reset inside both sync pulses.
    reset = 1'b0;
    @(negedge clk25M);
    reset = 1'b1;
    repeat (9500) @(negedge clk25M);
    chk("pre_midreset", cur_obs(), '{x: 10'd700, y: 10'd11, on: 1'b0, hs: 1'b0, vs: 1'b0,
                                     lt: 1'b0, ft: 1'b0, rgb: 3'b000});
    reset = 1'b0;
    @(negedge clk25M);
    chk("post_midreset", cur_obs(), '{x: 10'd0, y: 10'd0, on: 1'b1, hs: 1'b1, vs: 1'b1,
                                      lt: 1'b0, ft: 1'b0, rgb: 3'b000});
    reset = 1'b1;

    // Random reset pulses at random positions; the per-cycle model check covers these.
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(1, 2000)) @(negedge clk25M);
      reset = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk25M);
      reset = 1'b1;
    end
    repeat (5) @(negedge clk25M);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
